// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm stage: FSM state encoding and the
// time-of-day limits it has in common with the real-time clock counter.
// No ports; imported by alarm_unit.
package alarm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t RINGING = 2'd2;
    localparam state_t SNOOZE  = 2'd3;

    localparam logic [6:0] MAX_SEC  = 7'd59;
    localparam logic [6:0] MAX_MIN  = 7'd59;
    localparam logic [5:0] MAX_HOUR = 6'd23;

endpackage

// File: rtl/alarm_unit.sv
// Alarm stage after the RTC counter: stores an alarm time, rings a 0.5 Hz
// buzzer on match, supports bounded snoozes, manual stop and ring timeout.
// Ports: Clk_1sec/reset (sync, active-high); seconds/minutes/hours current
// time; alarm_en level arm; alarm_set + set_alarm_* load; snooze/stop
// requests; outputs alarm_minutes/alarm_hours, buzzer, ringing, snoozing,
// missed (sticky ring-timeout flag). All outputs come straight from flops.
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic [6:0] seconds,
    input  logic [6:0] minutes,
    input  logic [5:0] hours,
    input  logic       alarm_en,
    input  logic       alarm_set,
    input  logic [6:0] set_alarm_minutes,
    input  logic [5:0] set_alarm_hours,
    input  logic       snooze,
    input  logic       stop,
    output logic [6:0] alarm_minutes,
    output logic [5:0] alarm_hours,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic       missed
);

    // One timer is shared by RINGING and SNOOZE, sized for the longer phase.
    localparam int TMAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int CW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [TW-1:0] RING_LAST = TW'(RING_SECS - 1);
    localparam logic [TW-1:0] SNZ_LAST  = TW'(SNOOZE_SECS - 1);
    localparam logic [CW-1:0] SNZ_MAX   = CW'(MAX_SNOOZE);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] snz_cnt_q, snz_cnt_d;
    logic [6:0]    alm_min_q, alm_min_d;
    logic [5:0]    alm_hr_q, alm_hr_d;
    logic          buzzer_q, buzzer_d;
    logic          ringing_q, ringing_d;
    logic          snoozing_q, snoozing_d;
    logic          missed_q, missed_d;

    logic load_ok;
    logic match;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        snz_cnt_d = snz_cnt_q;
        alm_min_d = alm_min_q;
        alm_hr_d  = alm_hr_q;
        missed_d  = missed_q;
        buzzer_d  = 1'b0;

        // A load is accepted only when both fields are in range.
        load_ok = alarm_set && (set_alarm_minutes <= MAX_MIN)
                            && (set_alarm_hours <= MAX_HOUR);
        match   = (hours == alm_hr_q) && (minutes == alm_min_q)
                  && (seconds == 7'd0);

        if (load_ok) begin
            alm_min_d = set_alarm_minutes;
            alm_hr_d  = set_alarm_hours;
            missed_d  = 1'b0;
            snz_cnt_d = '0;
            timer_d   = '0;
            state_d   = alarm_en ? ARMED : IDLE;
        end else if (!alarm_en) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (match) begin
                        state_d   = RINGING;
                        timer_d   = '0;
                        snz_cnt_d = '0;
                        buzzer_d  = 1'b1;
                    end
                end
                RINGING: begin
                    // Stop beats snooze; snooze with no budget left acts as stop.
                    if (stop || (snooze && (snz_cnt_q >= SNZ_MAX))) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end else if (snooze) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = snz_cnt_q + CW'(1);
                        timer_d   = '0;
                    end else if (timer_q == RING_LAST) begin
                        state_d  = ARMED;
                        missed_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        timer_d  = timer_q + TW'(1);
                        buzzer_d = ~buzzer_q;
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end else if (timer_q == SNZ_LAST) begin
                        state_d  = RINGING;
                        timer_d  = '0;
                        buzzer_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            snz_cnt_q  <= '0;
            alm_min_q  <= '0;
            alm_hr_q   <= '0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            snz_cnt_q  <= snz_cnt_d;
            alm_min_q  <= alm_min_d;
            alm_hr_q   <= alm_hr_d;
            buzzer_q   <= buzzer_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
            missed_q   <= missed_d;
        end
    end

    assign alarm_minutes = alm_min_q;
    assign alarm_hours   = alm_hr_q;
    assign buzzer        = buzzer_q;
    assign ringing       = ringing_q;
    assign snoozing      = snoozing_q;
    assign missed        = missed_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Testbench for alarm_unit: directed scenarios followed by randomized
// stimulus, every cycle compared against a countdown-based reference model.
module tb_alarm_unit;

    localparam int RING = 60;
    localparam int SNZ  = 300;
    localparam int MAXS = 3;

    logic       Clk_1sec = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seconds = '0, minutes = '0;
    logic [5:0] hours = '0;
    logic       alarm_en = 1'b0, alarm_set = 1'b0;
    logic [6:0] set_alarm_minutes = '0;
    logic [5:0] set_alarm_hours = '0;
    logic       snooze = 1'b0, stop = 1'b0;
    logic [6:0] alarm_minutes;
    logic [5:0] alarm_hours;
    logic       buzzer, ringing, snoozing, missed;

    alarm_unit #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
        .Clk_1sec(Clk_1sec), .reset(reset),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .alarm_en(alarm_en), .alarm_set(alarm_set),
        .set_alarm_minutes(set_alarm_minutes), .set_alarm_hours(set_alarm_hours),
        .snooze(snooze), .stop(stop),
        .alarm_minutes(alarm_minutes), .alarm_hours(alarm_hours),
        .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .missed(missed)
    );

    always #5 Clk_1sec = ~Clk_1sec;

    // Reference model: remaining-ticks countdowns rather than an up-timer.
    int m_active = 0;     // alarm armed (or busy ringing/snoozing)
    int m_ring_left = 0;  // ringing cycles still to go, 0 = not ringing
    int m_snz_left = 0;   // snooze cycles still to go, 0 = not snoozing
    int m_age = 0;        // cycles since this ring burst started
    int m_used = 0;       // snoozes consumed for this alarm event
    int m_missed = 0;
    int m_amin = 0, m_ahr = 0;

    int n_cmp = 0, n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_active = 0; m_ring_left = 0; m_snz_left = 0; m_age = 0;
            m_used = 0; m_missed = 0; m_amin = 0; m_ahr = 0;
        end else if (alarm_set && set_alarm_minutes <= 59 && set_alarm_hours <= 23) begin
            m_amin = set_alarm_minutes; m_ahr = set_alarm_hours;
            m_missed = 0; m_used = 0; m_ring_left = 0; m_snz_left = 0;
            m_active = alarm_en ? 1 : 0;
        end else if (!alarm_en) begin
            m_active = 0; m_ring_left = 0; m_snz_left = 0;
        end else if (m_ring_left > 0) begin
            if (stop || (snooze && m_used == MAXS)) begin
                m_ring_left = 0;
            end else if (snooze) begin
                m_used++; m_ring_left = 0; m_snz_left = SNZ;
            end else if (m_ring_left == 1) begin
                m_ring_left = 0; m_missed = 1;
            end else begin
                m_ring_left--; m_age++;
            end
        end else if (m_snz_left > 0) begin
            if (stop) m_snz_left = 0;
            else if (m_snz_left == 1) begin
                m_snz_left = 0; m_ring_left = RING; m_age = 0;
            end else m_snz_left--;
        end else if (m_active != 0) begin
            if (hours == m_ahr && minutes == m_amin && seconds == 0) begin
                m_ring_left = RING; m_age = 0; m_used = 0;
            end
        end else begin
            m_active = 1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours = 6'(h); minutes = 7'(m); seconds = 7'(s);
    endtask

    // One 1 Hz tick: edge, model update, compare on the falling edge,
    // then advance the wall clock and drop one-shot requests.
    task automatic step();
        @(posedge Clk_1sec);
        model_step();
        @(negedge Clk_1sec);
        check("ringing", ringing, (m_ring_left > 0));
        check("snoozing", snoozing, (m_snz_left > 0));
        check("buzzer", buzzer, (m_ring_left > 0) && (m_age % 2 == 0));
        check("missed", missed, m_missed);
        check("alarm_minutes", alarm_minutes, m_amin);
        check("alarm_hours", alarm_hours, m_ahr);
        alarm_set = 1'b0; snooze = 1'b0; stop = 1'b0;
        if (seconds == 59) begin
            seconds = 0;
            if (minutes == 59) begin
                minutes = 0;
                hours = (hours == 23) ? 6'd0 : hours + 6'd1;
            end else minutes = minutes + 7'd1;
        end else seconds = seconds + 7'd1;
    endtask

    task automatic wait_ring(input string tag);
        for (int i = 0; i < 400 && m_ring_left == 0; i++) step();
        check(tag, ringing, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Load 06:07 and ring until auto-stop
        alarm_en = 1'b1; alarm_set = 1'b1;
        set_alarm_minutes = 7'd7; set_alarm_hours = 6'd6;
        step();
        set_time(6, 6, 57);
        wait_ring("ring_first");
        check("first_buzz", buzzer, 1);
        step(); check("buzz_t2", buzzer, 0);
        step(); check("buzz_t3", buzzer, 1);
        for (int i = 0; i < 70 && m_ring_left > 0; i++) step();
        check("timeout_missed", missed, 1);
        check("timeout_ring", ringing, 0);

        // Three snoozes, the fourth acts as stop
        set_time(6, 6, 58);
        for (int k = 0; k <= MAXS; k++) begin
            wait_ring("ring_snz");
            step(); step();
            snooze = 1'b1;
            step();
            if (k < MAXS) check("snoozing_on", snoozing, 1);
            else begin
                check("snz4_ring", ringing, 0);
                check("snz4_buzz", buzzer, 0);
                check("snz4_snoozing", snoozing, 0);
            end
        end

        // stop and snooze together
        set_time(6, 6, 59);
        wait_ring("ring_both");
        step();
        stop = 1'b1; snooze = 1'b1;
        step();
        check("both_snoozing", snoozing, 0);
        check("both_ringing", ringing, 0);

        // Out-of-range loads leave both registers alone
        alarm_set = 1'b1; set_alarm_minutes = 7'd60; set_alarm_hours = 6'd5;
        step();
        check("bad_min_keep_m", alarm_minutes, 7);
        check("bad_min_keep_h", alarm_hours, 6);
        alarm_set = 1'b1; set_alarm_minutes = 7'd3; set_alarm_hours = 6'd24;
        step();
        check("bad_hr_keep_m", alarm_minutes, 7);

        // Disarm while snoozing
        set_time(6, 6, 59);
        wait_ring("ring_en");
        snooze = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        alarm_en = 1'b0;
        step();
        check("en_off_snoozing", snoozing, 0);
        alarm_en = 1'b1;
        step();

        // Reset during a ring
        set_time(6, 6, 59);
        wait_ring("ring_rst");
        step(); step(); step();
        reset = 1'b1;
        step();
        check("rst_ringing", ringing, 0);
        check("rst_buzzer", buzzer, 0);
        check("rst_alm_min", alarm_minutes, 0);
        reset = 1'b0;
        set_time(6, 6, 58);
        for (int i = 0; i < 6; i++) step();
        check("rst_no_ring", ringing, 0);

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (alarm_en && $urandom_range(0, 199) == 0) alarm_en = 1'b0;
            else if (!alarm_en && $urandom_range(0, 19) == 0) alarm_en = 1'b1;
            if ($urandom_range(0, 149) == 0) begin
                alarm_set = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin
                        set_alarm_minutes = 7'($urandom_range(60, 127));
                        set_alarm_hours = 6'($urandom_range(0, 23));
                    end
                    1: begin
                        set_alarm_minutes = 7'($urandom_range(0, 59));
                        set_alarm_hours = 6'($urandom_range(24, 63));
                    end
                    default: begin
                        set_alarm_hours = hours;
                        set_alarm_minutes = (minutes == 59) ? 7'd0 : minutes + 7'd1;
                    end
                endcase
            end
            snooze = ($urandom_range(0, 29) == 0);
            stop = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 249) == 0)
                set_time(m_ahr, m_amin, $urandom_range(0, 3) == 0 ?
                         $urandom_range(1, 59) : $urandom_range(50, 59));
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
